// File: rtl/ysyx_23060042_ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one aligned request at a time to
// instruction memory, and hands the returned word plus its PC to decode.
module ysyx_23060042_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] redir_tgt;
  logic        discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    redir_tgt     = redirect_pc & ~32'h3;
    // A response is stale if a redirect arrived while it was in flight or alongside it.
    discard       = drop_q | redirect_valid;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = redir_tgt;
      end
      FETCH: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (imem_req_ready) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d   = redir_tgt;
          drop_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (discard) begin
            state_d = FETCH;
          end else begin
            state_d   = HOLD;
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end
      end
      HOLD: begin
        if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          pc_d          = pc_q + 32'd4;
          state_d       = FETCH;
        end
        // Redirect target overrides the sequential PC even when decode consumes.
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == FETCH);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_count    = fetch_count_q;

endmodule
